// File: rtl/mult_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_tile_sequencer
// Description : Sequential WIDTH x WIDTH unsigned multiplier controller that
//               time-shares one external 2x2 multiplier tile over every
//               (a-digit, b-digit) pair and accumulates the shifted partial
//               products. Valid/ready handshakes on operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_tile_sequencer #(
    parameter int WIDTH = 8            // operand width, even and >= 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [1:0]           tile_a,
    output logic [1:0]           tile_b,
    input  logic [3:0]           tile_p
);

    // Digit count, product width, digit-index width and shift-amount width.
    localparam int D_DIGITS = WIDTH / 2;
    localparam int PW       = 2 * WIDTH;
    localparam int IW       = (D_DIGITS > 1) ? $clog2(D_DIGITS) : 1;
    localparam int SW       = $clog2(PW) + 1;

    localparam logic [IW-1:0] C_LAST_DIGIT = IW'(D_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // Step counter k is kept as its two coordinates: i (a digit, outer) and
    // j (b digit, inner), so k = i*D + j without needing a divider.
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     j_q, j_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     product_q, product_d;

    logic              w_last_step;
    logic              w_last_j;
    logic [SW-1:0]     w_shift;
    logic [PW-1:0]     w_partial;
    logic [PW-1:0]     w_acc_sum;

    // Digits are presented to the tile only while stepping; zero otherwise.
    always_comb begin
        tile_a = 2'b00;
        tile_b = 2'b00;
        if (state_q == S_RUN) begin
            tile_a = a_q[2*i_q +: 2];
            tile_b = b_q[2*j_q +: 2];
        end
    end

    // Partial product weighted by 4^(i+j), plus the running sum.
    always_comb begin
        w_shift     = SW'(i_q) + SW'(j_q);
        w_partial   = PW'(tile_p) << {w_shift, 1'b0};
        w_acc_sum   = acc_q + w_partial;
        w_last_j    = (j_q == C_LAST_DIGIT);
        w_last_step = (i_q == C_LAST_DIGIT) && w_last_j;
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        i_d       = i_q;
        j_d       = j_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = w_acc_sum;
                if (w_last_step) begin
                    // Final step: publish the completed sum and rewind k.
                    product_d = w_acc_sum;
                    i_d       = '0;
                    j_d       = '0;
                    state_d   = S_DONE;
                end else if (w_last_j) begin
                    j_d = '0;
                    i_d = i_q + IW'(1);
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: captured operands, accumulator, digit indices, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product_q <= product_d;
        end
    end

    // Handshake and status outputs; in_ready is held low while reset is applied.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_tile_sequencer
// Description : Self-checking bench for mult_tile_sequencer at WIDTH=8 and
//               WIDTH=2, each driving a behavioural 2x2 tile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_tile_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=8 instance signals
    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic [1:0]  ta8, tb8;
    logic [3:0]  tp8;

    // WIDTH=2 instance signals
    logic        iv2, ir2, ov2, or2, busy2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic [1:0]  ta2, tb2;
    logic [3:0]  tp2;

    // Behavioural 2x2 tiles
    assign tp8 = {2'b00, ta8} * {2'b00, tb8};
    assign tp2 = {2'b00, ta2} * {2'b00, tb2};

    mult_tile_sequencer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8),
        .tile_a(ta8), .tile_b(tb8), .tile_p(tp8)
    );

    mult_tile_sequencer #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .product(p2), .busy(busy2),
        .tile_a(ta2), .tile_b(tb2), .tile_p(tp2)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; stall = cycles out_ready is held low after out_valid.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int stall,
                        output logic [15:0] prod, output int lat);
        int guard;
        guard = 0;
        while (!ir8 && guard < 50) begin
            tick();
            guard++;
        end
        chk("in_ready before accept", {63'd0, ir8}, 64'd1);
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        or8 = (stall == 0);
        tick();
        iv8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        lat = 1;
        while (!ov8 && lat < 100) begin
            tick();
            lat++;
        end
        if (!ov8) begin
            chk("out_valid timeout", {63'd0, ov8}, 64'd1);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
        end
        or8  = 1'b1;
        prod = p8;
        tick();
        chk("single result per op", {63'd0, ov8}, 64'd0);
    endtask

    // One WIDTH=2 operation with out_ready held high.
    task automatic run2(input logic [1:0] a, input logic [1:0] b,
                        output logic [3:0] prod, output int lat);
        a2  = a;
        b2  = b;
        iv2 = 1'b1;
        or2 = 1'b1;
        tick();
        iv2 = 1'b0;
        lat = 1;
        while (!ov2 && lat < 20) begin
            tick();
            lat++;
        end
        prod = p2;
        tick();
        chk("w2 single result", {63'd0, ov2}, 64'd0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        logic [3:0]  q;
        logic [7:0]  ra, rb;
        int          lat;
        int          guard;

        tbl[0] = '{8'd255, 8'd255, 16'd65025};
        tbl[1] = '{8'd0,   8'd173, 16'd0};
        tbl[2] = '{8'd1,   8'd173, 16'd173};
        tbl[3] = '{8'd200, 8'd37,  16'd7400};
        tbl[4] = '{8'd12,  8'd13,  16'd156};
        tbl[5] = '{8'd1,   8'd1,   16'd1};
        tbl[6] = '{8'd255, 8'd1,   16'd255};
        tbl[7] = '{8'd128, 8'd2,   16'd256};
        tbl[8] = '{8'd170, 8'd85,  16'd14450};
        tbl[9] = '{8'd15,  8'd240, 16'd3600};

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        iv2 = 1'b0; or2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
        tick();
        tick();

        // Reset state
        chk("reset in_ready low", {63'd0, ir8}, 64'd0);
        chk("reset out_valid", {63'd0, ov8}, 64'd0);
        chk("reset busy", {63'd0, busy8}, 64'd0);
        chk("reset product", {48'd0, p8}, 64'd0);
        chk("reset tile_a", {62'd0, ta8}, 64'd0);
        chk("reset tile_b", {62'd0, tb8}, 64'd0);
        chk("w2 reset out_valid", {63'd0, ov2}, 64'd0);
        chk("w2 reset product", {60'd0, p2}, 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", {63'd0, ir8}, 64'd1);
        chk("w2 in_ready after reset", {63'd0, ir2}, 64'd1);
        tick();

        // Table-driven vectors, out_ready held high
        for (int v = 0; v < 10; v++) begin
            run8(tbl[v].a, tbl[v].b, 0, p, lat);
            chk($sformatf("vec%0d product", v), {48'd0, p}, {48'd0, tbl[v].p});
            chk($sformatf("vec%0d latency", v), 64'(lat), 64'd17);
            chk($sformatf("vec%0d idle after", v), {63'd0, ir8}, 64'd1);
        end

        // Tile digit order: a digits 0,1,2,3 (LSB first), b digits 3,2,1,0
        a8 = 8'hE4; b8 = 8'h1B; iv8 = 1'b1; or8 = 1'b1;
        tick();
        iv8 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("step%0d tile_a", k), {62'd0, ta8}, 64'(k / 4));
            chk($sformatf("step%0d tile_b", k), {62'd0, tb8}, 64'(3 - (k % 4)));
            chk($sformatf("step%0d out_valid", k), {63'd0, ov8}, 64'd0);
            tick();
        end
        chk("order out_valid", {63'd0, ov8}, 64'd1);
        chk("order product", {48'd0, p8}, 64'd6156);
        chk("done tile_a zero", {62'd0, ta8}, 64'd0);
        chk("done tile_b zero", {62'd0, tb8}, 64'd0);
        tick();

        // Back-pressure with a competing operand offer during DONE
        a8 = 8'd200; b8 = 8'd37; iv8 = 1'b1; or8 = 1'b0;
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 100) begin
            tick();
            lat++;
        end
        chk("bp latency", 64'(lat), 64'd17);
        for (int c = 0; c < 10; c++) begin
            a8 = 8'd5; b8 = 8'd7; iv8 = 1'b1;
            chk($sformatf("bp%0d product", c), {48'd0, p8}, 64'd7400);
            chk($sformatf("bp%0d out_valid", c), {63'd0, ov8}, 64'd1);
            chk($sformatf("bp%0d in_ready", c), {63'd0, ir8}, 64'd0);
            tick();
        end
        or8 = 1'b1;
        tick();
        chk("bp idle in_ready", {63'd0, ir8}, 64'd1);
        chk("bp idle busy", {63'd0, busy8}, 64'd0);
        chk("bp product kept", {48'd0, p8}, 64'd7400);
        tick();
        iv8 = 1'b0;
        chk("bp new op busy", {63'd0, busy8}, 64'd1);
        lat = 1;
        while (!ov8 && lat < 100) begin
            tick();
            lat++;
        end
        chk("bp new op latency", 64'(lat), 64'd17);
        chk("bp new op product", {48'd0, p8}, 64'd35);
        tick();

        // Reset while in RUN
        a8 = 8'd99; b8 = 8'd99; iv8 = 1'b1; or8 = 1'b1;
        tick();
        iv8 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        chk("pre-reset busy", {63'd0, busy8}, 64'd1);
        rst = 1'b1;
        tick();
        chk("midrun rst out_valid", {63'd0, ov8}, 64'd0);
        chk("midrun rst busy", {63'd0, busy8}, 64'd0);
        chk("midrun rst product", {48'd0, p8}, 64'd0);
        chk("midrun rst in_ready", {63'd0, ir8}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post rst in_ready", {63'd0, ir8}, 64'd1);
        guard = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ov8) guard++;
        end
        chk("no out_valid after rst", 64'(guard), 64'd0);
        run8(8'd12, 8'd13, 0, p, lat);
        chk("post rst product", {48'd0, p}, 64'd156);
        chk("post rst latency", 64'(lat), 64'd17);

        // Random operands with random result stalls and idle gaps
        for (int r = 0; r < 1000; r++) begin
            int stall;
            ra = 8'($urandom);
            rb = 8'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            if ($urandom_range(0, 3) == 0) tick();
            run8(ra, rb, stall, p, lat);
            chk($sformatf("rnd%0d %0dx%0d", r, ra, rb), {48'd0, p}, 64'(ra) * 64'(rb));
        end

        // WIDTH=2 exhaustive sweep
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                run2(2'(x), 2'(y), q, lat);
                chk($sformatf("w2 %0dx%0d product", x, y), {60'd0, q}, 64'(x * y));
                chk($sformatf("w2 %0dx%0d latency", x, y), 64'(lat), 64'd2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_tile_sequencer.md
# mult_tile_sequencer

Sequential WIDTH×WIDTH unsigned multiplier controller. It builds a full product by time-sharing one external 2×2 multiplier tile (A[1:0], B[1:0] → P[3:0]) over every digit pair and accumulating the shifted partial products. The tile sits outside this block, so any generated 2×2 multiplier architecture can be swapped in and checked at larger widths without changing the controller. Valid/ready handshakes on both the operand and result sides.

## Interface
- WIDTH, 8, operand width in bits; even, ≥2. Digit count D = WIDTH/2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  unsigned a*b.
- busy  out  1  high in RUN or DONE.
- tile_a  out  2  digit of captured a driven to the tile.
- tile_b  out  2  digit of captured b driven to the tile.
- tile_p  in  4  tile result; purely combinational from tile_a and tile_b in the same cycle.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: capture a→a_reg and b→b_reg, clear acc and step counter k, go to RUN.
- RUN, one digit pair per cycle, k = 0..D*D-1:
  - i = k / D (outer, a digit); j = k mod D (inner, b digit).
  - tile_a = a_reg[2i+1:2i]; tile_b = b_reg[2j+1:2j].
  - acc <= acc + (zero-extended tile_p << 2(i+j)).
  - Accumulation is 2*WIDTH bits wide and cannot overflow, since the final result is < 2^(2·WIDTH).
  - After the step with k = D*D-1, go to DONE.
- DONE
  - out_valid=1 and product=acc, both held stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
- Outside RUN: tile_a=0, tile_b=0; tile_p is ignored.
- Inputs a, b and in_valid are ignored outside IDLE. Operands are not re-sampled during RUN.
- The product register keeps its last value after the handshake and is overwritten only at the next DONE entry. product is not qualified when out_valid=0.
- in_ready = (state==IDLE). busy = (state!=IDLE).

## Timing
- Reset values, applied on the first edge with rst=1:
  - State IDLE, acc=0, k=0.
  - product=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after rst deasserts; in_ready=0 while rst is high.
- Reset mid-operation (RUN or DONE): the transaction is discarded, IDLE is entered, and no out_valid pulse is produced.
- Latency: accept edge at cycle t; RUN occupies cycles t+1 .. t+D*D; out_valid rises at cycle t+D*D+1. For WIDTH=8 that is 17 cycles.
- Throughput with out_ready held at 1: DONE lasts 1 cycle and IDLE lasts 1 cycle, so a new accept is possible at cycle t+D*D+2. One operation per D*D+2 cycles.
- Back-pressure: DONE is held indefinitely while out_ready=0; in_ready stays 0.
- A simultaneous in_valid during DONE has no effect. It is accepted only once IDLE is entered.
- k wraps to 0 on RUN exit. No other wrap-around exists.
- WIDTH=2 (D=1): RUN lasts exactly one cycle, i=j=0, shift 0.

## Test plan
- WIDTH=8: a=255, b=255, out_ready=1 → out_valid at accept+17, product=65025. tile_a/tile_b must step through all 16 (i,j) pairs in the order (0,0),(0,1)…(3,3).
- WIDTH=8: a=0, b=173 → product=0. Then a=1, b=173 → product=173. Each takes full latency; there is no early termination.
- Back-pressure: a=200, b=37, out_ready=0 for 10 cycles after out_valid. Required:
  - product=7400 stays stable and in_ready stays 0 throughout.
  - A new in_valid offered meanwhile is not taken.
  - Raising out_ready completes the handshake; the new operands are accepted in the following IDLE cycle.
- Reset mid-RUN: a=99, b=99, assert rst at accept+5 → next cycle state IDLE, out_valid=0, product=0, in_ready=1 after rst drops. The next op 12×13 returns 156.
- Back-to-back random: 1000 random pairs with random out_ready stalls. Each product must equal a*b and every accepted op must produce exactly one result.
- WIDTH=2: a=3, b=3 → out_valid at accept+2, product=9. Sweep all 16 input pairs exhaustively.
